// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply-divide unit.
// The pipeline side drives requests; the unit returns busy and the HI/LO contents.
interface hilo_muldiv_if #(
  parameter int W = 32
);
  logic         op_valid;
  logic [3:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         busy;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  busy, hi_o, lo_o
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output busy, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with single-cycle multiply/move and a W+1 cycle restoring divider.
// Define HILO_MADD_EN to enable the single-cycle MADD/MADDU/MSUB/MSUBU accumulate ops.
module hilo_muldiv #(
  parameter int W = 32
) (
  input logic          clk,
  input logic          resetn,
  hilo_muldiv_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef HILO_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [W-1:0]  ZERO_W  = {W{1'b0}};
  localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ONES_W  = {W{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_W   = CW'(W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [W-1:0]  hi_r, hi_s;
  logic [W-1:0]  lo_r, lo_s;
  logic [W-1:0]  quo_r, quo_s;
  logic [W-1:0]  rem_r, rem_s;
  logic [W-1:0]  dvs_r, dvs_s;
  logic [W-1:0]  a_raw_r, a_raw_s;
  logic          q_neg_r, q_neg_s;
  logic          r_neg_r, r_neg_s;
  logic          div_zero_r, div_zero_s;
  logic          busy_r;

  logic            accept_s;
  logic            sgn_s;
  logic [2*W-1:0]  a_ext_s;
  logic [2*W-1:0]  b_ext_s;
  logic [2*W-1:0]  prod_s;
  logic [W:0]      shift_s;
  logic            ge_s;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
    if (is_signed && v[W-1]) begin
      magnitude = ~v + ONE_W;
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic [W-1:0] apply_sign(input logic [W-1:0] v, input logic neg);
    if (neg) begin
      apply_sign = ~v + ONE_W;
    end else begin
      apply_sign = v;
    end
  endfunction

  assign accept_s = bus.op_valid && !busy_r && !bus.flush;

  // Decode whether the presented op treats its operands as signed.
  always_comb begin
    sgn_s = 1'b0;
    case (bus.op)
      OP_MULT:  sgn_s = 1'b1;
      OP_DIV:   sgn_s = 1'b1;
`ifdef HILO_MADD_EN
      OP_MADD:  sgn_s = 1'b1;
      OP_MSUB:  sgn_s = 1'b1;
`endif
      default:  sgn_s = 1'b0;
    endcase
  end

  // Sign-extending to 2W lets one 2W-bit multiply serve both signed and unsigned ops.
  assign a_ext_s = sgn_s ? {{W{bus.src_a[W-1]}}, bus.src_a} : {ZERO_W, bus.src_a};
  assign b_ext_s = sgn_s ? {{W{bus.src_b[W-1]}}, bus.src_b} : {ZERO_W, bus.src_b};
  assign prod_s  = a_ext_s * b_ext_s;

  // Restoring step: the partial remainder is always below the divisor, so the
  // subtraction result fits in W bits whenever it is taken.
  assign shift_s = {rem_r, quo_r[W-1]};
  assign ge_s    = shift_s[W] || (shift_s[W-1:0] >= dvs_r);

  // Next-state, divider datapath and HI/LO write selection.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    quo_s      = quo_r;
    rem_s      = rem_r;
    dvs_s      = dvs_r;
    a_raw_s    = a_raw_r;
    q_neg_s    = q_neg_r;
    r_neg_s    = r_neg_r;
    div_zero_s = div_zero_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              {hi_s, lo_s} = prod_s;
            end
            OP_MTHI: begin
              hi_s = bus.src_a;
            end
            OP_MTLO: begin
              lo_s = bus.src_a;
            end
            OP_DIV, OP_DIVU: begin
              state_s    = ST_DIV;
              cnt_s      = CNT_W;
              quo_s      = magnitude(bus.src_a, sgn_s);
              dvs_s      = magnitude(bus.src_b, sgn_s);
              rem_s      = ZERO_W;
              a_raw_s    = bus.src_a;
              q_neg_s    = sgn_s && (bus.src_a[W-1] ^ bus.src_b[W-1]);
              r_neg_s    = sgn_s && bus.src_a[W-1];
              div_zero_s = (bus.src_b == ZERO_W);
            end
`ifdef HILO_MADD_EN
            OP_MADD, OP_MADDU: begin
              {hi_s, lo_s} = {hi_r, lo_r} + prod_s;
            end
            OP_MSUB, OP_MSUBU: begin
              {hi_s, lo_s} = {hi_r, lo_r} - prod_s;
            end
`endif
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_DIV: begin
        if (bus.flush) begin
          state_s = ST_IDLE;
          cnt_s   = {CW{1'b0}};
        end else begin
          quo_s = {quo_r[W-2:0], ge_s};
          rem_s = ge_s ? (shift_s[W-1:0] - dvs_r) : shift_s[W-1:0];
          cnt_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DIV;
          end
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
        if (bus.flush) begin
          hi_s = hi_r;
        end else if (div_zero_r) begin
          hi_s = a_raw_r;
          lo_s = ONES_W;
        end else begin
          hi_s = apply_sign(rem_r, r_neg_r);
          lo_s = apply_sign(quo_r, q_neg_r);
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // All architectural and divider state; reset discards any divide in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      hi_r       <= ZERO_W;
      lo_r       <= ZERO_W;
      quo_r      <= ZERO_W;
      rem_r      <= ZERO_W;
      dvs_r      <= ZERO_W;
      a_raw_r    <= ZERO_W;
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      div_zero_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      hi_r       <= hi_s;
      lo_r       <= lo_s;
      quo_r      <= quo_s;
      rem_r      <= rem_s;
      dvs_r      <= dvs_s;
      a_raw_r    <= a_raw_s;
      q_neg_r    <= q_neg_s;
      r_neg_r    <= r_neg_s;
      div_zero_r <= div_zero_s;
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  assign bus.busy = busy_r;
  assign bus.hi_o = hi_r;
  assign bus.lo_o = lo_r;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed vector table, hand-written divide/flush/reset
// sequences, then random ops checked against an arithmetic reference model.
module tb_hilo_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.W(W)) bus();
  hilo_muldiv #(.W(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural result.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint sa, sb;
    logic [63:0] ps, pu, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = 64'(sa * sb);
    pu = {32'h0, a} * {32'h0, b};
    case (op)
      4'd1: return ps;
      4'd2: return pu;
      4'd3, 4'd4: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (op == 4'd3) begin
          q = 64'(sa / sb);
          r = 64'(sa % sb);
        end else begin
          q = {32'h0, a} / {32'h0, b};
          r = {32'h0, a} % {32'h0, b};
        end
        return {r[31:0], q[31:0]};
      end
      4'd5: return {a, hl[31:0]};
      4'd6: return {hl[63:32], a};
`ifdef HILO_MADD_EN
      4'd7:  return hl + ps;
      4'd8:  return hl + pu;
      4'd9:  return hl - ps;
      4'd10: return hl - pu;
`endif
      default: return hl;
    endcase
  endfunction

  // Issue one op, wait out a divide (bounded), compare against expected; m_hi/m_lo = pre-op state.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    logic hold_ok;
    bus.op_valid = 1'b1;
    bus.op = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.op_valid = 1'b0;
    if (op == 4'd3 || op == 4'd4) begin
      cyc = 0;
      hold_ok = 1'b1;
      while (bus.busy === 1'b1 && cyc < 100) begin
        cyc++;
        if (bus.hi_o !== m_hi || bus.lo_o !== m_lo) hold_ok = 1'b0;
        tick();
      end
      check({name, "_busy_cycles"}, 32'(cyc), 32'd33);
      check({name, "_hold"}, {31'h0, hold_ok}, 32'h1);
    end else begin
      check({name, "_busy"}, {31'h0, bus.busy}, 32'h0);
    end
    check({name, "_hi"}, bus.hi_o, ehi);
    check({name, "_lo"}, bus.lo_o, elo);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] nx;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int cyc;

    vecs[0]  = '{4'd1,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{4'd5,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFA};
    vecs[2]  = '{4'd6,  32'h0000ABCD, 32'd0,        32'h12345678, 32'h0000ABCD};
    vecs[3]  = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[4]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5]  = '{4'd4,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF};
    vecs[6]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{4'd3,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{4'd4,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[9]  = '{4'd3,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[10] = '{4'd0,  32'd1,        32'd1,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[11] = '{4'd15, 32'd1,        32'd1,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[12] = '{4'd5,  32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF};
`ifdef HILO_MADD_EN
    vecs[13] = '{4'd8,  32'd1,        32'd1,        32'h00000001, 32'h00000000};
    vecs[14] = '{4'd9,  32'd1,        32'd2,        32'h00000000, 32'hFFFFFFFE};
`else
    vecs[13] = '{4'd8,  32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF};
    vecs[14] = '{4'd9,  32'd1,        32'd2,        32'h00000000, 32'hFFFFFFFF};
`endif
    vecs[15] = '{4'd4,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};

    bus.op_valid = 1'b0;
    bus.op = 4'd0;
    bus.src_a = 32'h0;
    bus.src_b = 32'h0;
    bus.flush = 1'b0;
    resetn = 1'b0;
    repeat (2) tick();
    check("reset_hi", bus.hi_o, 32'h0);
    check("reset_lo", bus.lo_o, 32'h0);
    check("reset_busy", {31'h0, bus.busy}, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);
    end

    // Divide with a MULT held on the bus while busy: accepted one edge after the result.
    bus.op_valid = 1'b1;
    bus.op = 4'd3;
    bus.src_a = 32'hFFFFFFF9;
    bus.src_b = 32'd2;
    tick();
    bus.op = 4'd1;
    bus.src_a = 32'd3;
    bus.src_b = 32'd5;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    check("held_div_cycles", 32'(cyc), 32'd33);
    check("held_div_hi", bus.hi_o, 32'hFFFFFFFF);
    check("held_div_lo", bus.lo_o, 32'hFFFFFFFD);
    tick();
    bus.op_valid = 1'b0;
    check("held_mult_hi", bus.hi_o, 32'h0);
    check("held_mult_lo", bus.lo_o, 32'hF);
    m_hi = 32'h0;
    m_lo = 32'hF;

    // Flush mid-divide leaves the preloaded HI/LO.
    run_op("pre_mthi", 4'd5, 32'd1, 32'd0, 32'd1, 32'hF);
    run_op("pre_mtlo", 4'd6, 32'd2, 32'd0, 32'd1, 32'd2);
    bus.op_valid = 1'b1;
    bus.op = 4'd4;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    tick();
    bus.op_valid = 1'b0;
    repeat (19) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_div_busy", {31'h0, bus.busy}, 32'h0);
    check("flush_div_hi", bus.hi_o, 32'd1);
    check("flush_div_lo", bus.lo_o, 32'd2);
    repeat (40) tick();
    check("flush_div_late_lo", bus.lo_o, 32'd2);

    // Flush in the DONE cycle suppresses the write.
    bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    repeat (32) tick();
    check("done_busy_before", {31'h0, bus.busy}, 32'h1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_done_busy", {31'h0, bus.busy}, 32'h0);
    check("flush_done_hi", bus.hi_o, 32'd1);
    check("flush_done_lo", bus.lo_o, 32'd2);

    // Flush together with a request in IDLE blocks acceptance.
    bus.op_valid = 1'b1;
    bus.op = 4'd5;
    bus.src_a = 32'hDEADBEEF;
    bus.flush = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    bus.flush = 1'b0;
    check("flush_idle_hi", bus.hi_o, 32'd1);

    // Asynchronous reset mid-divide clears everything immediately.
    bus.op_valid = 1'b1;
    bus.op = 4'd4;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    tick();
    bus.op_valid = 1'b0;
    repeat (9) tick();
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_hi", bus.hi_o, 32'h0);
    check("rst_mid_lo", bus.lo_o, 32'h0);
    check("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (40) tick();
    check("rst_after_hi", bus.hi_o, 32'h0);
    check("rst_after_lo", bus.lo_o, 32'h0);
    check("rst_after_busy", {31'h0, bus.busy}, 32'h0);
    m_hi = 32'h0;
    m_lo = 32'h0;

    // Random ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        1: rb = 32'h0;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = rb;
      endcase
      nx = model(rop, ra, rb, {m_hi, m_lo});
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, nx[63:32], nx[31:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO unit for the integer pipeline. It holds the HI/LO register pair and executes the operations that write it:
- multiply and move-to in a single cycle;
- divide iteratively over W+1 cycles, with a busy stall.

It sits beside the EX stage. The pipeline holds any HI/LO-writing instruction in EX while `busy` is high, and reads `hi_o`/`lo_o` directly (no internal forwarding).

## Interface
- W, 32, datapath width of operands, HI and LO (≥ 2)
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- op_valid  in  1  operation request this cycle
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, 11–15 NOP
- src_a  in  W  operand A (dividend / multiplicand / move source)
- src_b  in  W  operand B (divisor / multiplier)
- flush  in  1  cancel in-flight divide; suppress acceptance this cycle
- busy  out  1  divide in progress; new requests not accepted
- hi_o  out  W  HI register
- lo_o  out  W  LO register

## Operation
- A request is accepted at a rising edge only when all three hold: op_valid=1, busy=0, flush=0.
  - A request presented while busy=1 is not accepted; the producer holds it.
- MULT/MULTU: {hi,lo} ← 2W-bit product, signed or unsigned; written at the accepting edge.
- MTHI: hi ← src_a; lo unchanged. MTLO: lo ← src_a; hi unchanged. Both written at the accepting edge.
- DIV/DIVU (restoring, radix-2):
  - Accept latches |A|, |B| and the result signs.
  - Result: lo ← quotient, hi ← remainder.
  - Signed quotient is negative iff the operand signs differ. Remainder takes the dividend's sign.
  - Divisor 0: lo ← all ones, hi ← src_a, unchanged (signed and unsigned).
  - Signed −2^(W−1) / −1: lo ← −2^(W−1) (wraps), hi ← 0.
- FSM states:
  - IDLE → DIV on divide accept; counter ← W.
  - DIV: one quotient bit per edge, counter decrements. When counter reaches 0, → DONE.
  - DONE: write hi/lo, → IDLE.
  - flush=1 in DIV or DONE: → IDLE at that edge; no hi/lo write.
- busy = (state ≠ IDLE).
- All arithmetic is modulo 2^W per register, 2^(2W) for the pair.

## Timing
- Reset (resetn=0, asynchronous): hi_o=0, lo_o=0, busy=0, state=IDLE, counter=0. Takes effect immediately, including mid-divide; the result is discarded.
- Reset release is synchronous to clk; the first accept is possible at the first edge with resetn=1.
- Single-cycle ops: the new hi_o/lo_o value is visible right after the accepting edge; busy stays 0.
- Divide, with the accept at edge E0:
  - busy=1 from after E0 until after edge E0+W+1 (W+1 cycles).
  - hi_o/lo_o update at edge E0+W+1.
  - A new request can be accepted at edge E0+W+2.
- hi_o/lo_o are unchanged throughout a divide until the DONE write.
- flush and an op_valid in the same IDLE cycle: op is not accepted, no write.
- Flush in the DONE cycle: no write; busy=0 after that edge.

## Configuration
- HILO_MADD_EN defined: ops 7–10 are single-cycle accumulates.
  - MADD/MADDU: {hi,lo} ← {hi,lo} + product. MSUB/MSUBU: {hi,lo} ← {hi,lo} − product.
  - Product is signed or unsigned per op; result wraps at 2W bits.
  - Written at the accepting edge.
- HILO_MADD_EN undefined: ops 7–10 behave as NOP. No write, busy unaffected, no accumulator datapath synthesised.

## Test plan
All cases W=32.
- Reset mid-divide: start DIVU 100/7, assert resetn=0 at cycle 10 → hi_o=0, lo_o=0, busy=0 immediately; no write after release.
- MULT src_a=0xFFFFFFFE (−2), src_b=3 → next cycle hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA. Then MTHI 0x12345678 → hi_o=0x12345678, lo_o unchanged.
- DIV −7/2 accepted at E0 → busy high 33 cycles; at E0+33 lo_o=0xFFFFFFFD (−3), hi_o=0xFFFFFFFF (−1). A MULT held during busy is accepted at E0+34.
- DIVU 5/0 → lo_o=0xFFFFFFFF, hi_o=5. DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- Flush: start DIVU 100/7, hi/lo preloaded to 1/2, flush at cycle 20 → busy=0 next cycle, hi_o=1, lo_o=2.
- HILO_MADD_EN set: hi/lo=0/0xFFFFFFFF, MADDU 1×1 → hi_o=1, lo_o=0. Then MSUB 1×2 → hi_o=0, lo_o=0xFFFFFFFE. Macro undefined: same stimulus leaves hi/lo unchanged.
